tex_sample_arbiter: RTL and testbench

Round-robin scheduler that shares one texture sampling unit among NUM_REQ shader-core requesters. It accepts one sample request at a time over a valid/ready handshake. It drives the sampler's control interface and holds the coordinates stable until the sampler reports completion, then returns the texel to the granted requester. A watchdog timeout guarantees forward progress if the sampler never completes. It sits between the shader-core texture ports and the texture unit's control port.

---
 rtl/tex_sample_arbiter.sv | 123 ++++++++++++
 tb/tb_tex_sample_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tex_sample_arbiter.sv
// tex_sample_arbiter: round-robin scheduler sharing one texture sampler among NUM_REQ requesters
module tex_sample_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_tex_id,
  input  logic [16*NUM_REQ-1:0]  req_u,
  input  logic [16*NUM_REQ-1:0]  req_v,
  input  logic [8*NUM_REQ-1:0]   req_lod,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [127:0]           resp_texel,
  output logic                   resp_error,
  output logic                   tu_sample_en,
  output logic [31:0]            tu_tex_id,
  output logic [15:0]            tu_u,
  output logic [15:0]            tu_v,
  output logic [7:0]             tu_lod,
  input  logic                   tu_sample_done,
  input  logic [127:0]           tu_texel,
  output logic                   busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                   stray_done
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t state, state_nx;
  logic [GW-1:0] last_grant, pick, rr_idx;
  logic found, tmo, hs, accept;
  logic [CW-1:0] cnt;
  logic [31:0] sel_tex;
  logic [15:0] sel_u, sel_v;
  logic [7:0] sel_lod;
  logic [NUM_REQ-1:0] one;
  assign one          = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign hs           = state == IDLE && found;
  assign accept       = state == RESPOND && resp_ready[grant_id];
  assign tmo          = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign req_ready    = hs ? one << pick : '0;
  assign resp_valid   = state == RESPOND ? one << grant_id : '0;
  assign tu_sample_en = state == ISSUE;
  // search upward from the slot after the last grant, wrapping, for the first valid requester
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = GW'((int'(last_grant) + 1 + k) % NUM_REQ);
      if (!found && req_valid[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end
  // route the picked requester's sample fields to the latch inputs
  always_comb begin
    sel_tex = '0;
    sel_u   = '0;
    sel_v   = '0;
    sel_lod = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == pick) begin
        sel_tex = req_tex_id[32*i +: 32];
        sel_u   = req_u[16*i +: 16];
        sel_v   = req_v[16*i +: 16];
        sel_lod = req_lod[8*i +: 8];
      end
    end
  end
  // next state: done beats timeout in WAIT since either one leaves for RESPOND
  always_comb begin
    state_nx = hs ? ISSUE
             : state == ISSUE ? WAIT
             : (state == WAIT && (tu_sample_done || tmo)) ? RESPOND
             : accept ? IDLE
             : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // sampler fields, grant, watchdog and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      tu_tex_id  <= '0;
      tu_u       <= '0;
      tu_v       <= '0;
      tu_lod     <= '0;
      cnt        <= '0;
      resp_texel <= '0;
      resp_error <= 1'b0;
      busy       <= 1'b0;
      stray_done <= 1'b0;
    end else begin
      busy       <= state_nx != IDLE;
      stray_done <= tu_sample_done && state != WAIT;
      if (hs) begin
        grant_id  <= pick;
        tu_tex_id <= sel_tex;
        tu_u      <= sel_u;
        tu_v      <= sel_v;
        tu_lod    <= sel_lod;
      end
      cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      if (state == WAIT && tu_sample_done) begin
        resp_texel <= tu_texel;
        resp_error <= 1'b0;
      end else if (state == WAIT && tmo) begin
        resp_texel <= '0;
        resp_error <= 1'b1;
      end
      if (accept) last_grant <= grant_id;
    end
  end
endmodule

// File: tb/tb_tex_sample_arbiter.sv
// tb_tex_sample_arbiter: directed checks of grant order, latency, backpressure, timeout and reset
module tb_tex_sample_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [32*N-1:0] req_tex_id;
  logic [16*N-1:0] req_u, req_v;
  logic [8*N-1:0] req_lod;
  logic [127:0] resp_texel, tu_texel;
  logic resp_error, tu_sample_en, tu_sample_done, busy, stray_done;
  logic [31:0] tu_tex_id;
  logic [15:0] tu_u, tu_v;
  logic [7:0] tu_lod;
  logic [1:0] grant_id;
  logic [N-1:0] one;
  int total = 0;
  int bad = 0;
  tex_sample_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tex_id(req_tex_id), .req_u(req_u), .req_v(req_v), .req_lod(req_lod),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_texel(resp_texel),
    .resp_error(resp_error), .tu_sample_en(tu_sample_en), .tu_tex_id(tu_tex_id),
    .tu_u(tu_u), .tu_v(tu_v), .tu_lod(tu_lod), .tu_sample_done(tu_sample_done),
    .tu_texel(tu_texel), .busy(busy), .grant_id(grant_id), .stray_done(stray_done)
  );
  always #5 clk = ~clk;
  task chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #2;
  endtask
  task set_req(input int i, input logic [31:0] t, input logic [15:0] u, input logic [15:0] v, input logic [7:0] l);
    req_tex_id[32*i +: 32] = t;
    req_u[16*i +: 16] = u;
    req_v[16*i +: 16] = v;
    req_lod[8*i +: 8] = l;
  endtask
  task serve(input int lat, input logic [127:0] tx);
    repeat (lat) tick;
    chk("pre_resp", resp_valid, 0);
    tu_sample_done = 1'b1;
    tu_texel = tx;
    tick;
    tu_sample_done = 1'b0;
    tu_texel = '0;
  endtask
  initial begin
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_tex_id = '0;
    req_u = '0;
    req_v = '0;
    req_lod = '0;
    tu_sample_done = 1'b0;
    tu_texel = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_tex", tu_tex_id, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_stray", stray_done, 0);
    chk("rst_texel", resp_texel, 0);
    tick;
    rst = 1'b0;
    tick;
    set_req(2, 32'h10, 16'h1234, 16'h5678, 8'd3);
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_en_pre", tu_sample_en, 0);
    tick;
    req_valid = '0;
    chk("t1_en", tu_sample_en, 1);
    chk("t1_tex", tu_tex_id, 32'h10);
    chk("t1_u", tu_u, 16'h1234);
    chk("t1_v", tu_v, 16'h5678);
    chk("t1_lod", tu_lod, 3);
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    tick;
    chk("t1_en_off", tu_sample_en, 0);
    serve(4, {16{8'hA5}});
    chk("t1_resp_valid", resp_valid, 4'b0100);
    chk("t1_texel", resp_texel, {16{8'hA5}});
    chk("t1_err", resp_error, 0);
    resp_ready = 4'b0100;
    tick;
    resp_ready = '0;
    chk("t1_resp_clear", resp_valid, 0);
    chk("t1_idle", busy, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 32'h20 + i, 16'h100 + 16'(i), 16'h200, 8'(i));
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      one = 4'b0001 << (g % N);
      #1;
      chk("rr_ready", req_ready, one);
      tick;
      chk("rr_grant", grant_id, g % N);
      chk("rr_u", tu_u, 16'h100 + 16'(g % N));
      serve(1, 128'(g + 1));
      chk("rr_resp_valid", resp_valid, one);
      chk("rr_texel", resp_texel, g + 1);
      resp_ready = one;
      tick;
      resp_ready = '0;
    end
    req_valid = '0;
    set_req(1, 32'hB1, 16'hAAAA, 16'hBBBB, 8'd7);
    req_valid = 4'b0010;
    #1;
    chk("bp_ready", req_ready, 4'b0010);
    tick;
    req_valid = 4'b1101;
    serve(2, {8{16'h1111}});
    resp_ready = 4'b1101;
    repeat (10) begin
      chk("bp_resp_valid", resp_valid, 4'b0010);
      chk("bp_texel", resp_texel, {8{16'h1111}});
      chk("bp_u", tu_u, 16'hAAAA);
      chk("bp_ready_hold", req_ready, 0);
      tick;
    end
    resp_ready = 4'b0010;
    tick;
    resp_ready = '0;
    chk("bp_next", req_ready, 4'b0100);
    chk("bp_resp_clear", resp_valid, 0);
    req_valid = '0;
    set_req(3, 32'h33, 16'h3, 16'h4, 8'd1);
    req_valid = 4'b1000;
    #1;
    chk("to_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    chk("to_en", tu_sample_en, 1);
    repeat (TO) tick;
    chk("to_pre", resp_valid, 0);
    chk("to_busy", busy, 1);
    tick;
    chk("to_resp_valid", resp_valid, 4'b1000);
    chk("to_err", resp_error, 1);
    chk("to_texel", resp_texel, 0);
    resp_ready = 4'b1000;
    tick;
    resp_ready = '0;
    chk("to_idle", busy, 0);
    tu_sample_done = 1'b1;
    tick;
    tu_sample_done = 1'b0;
    chk("to_stray", stray_done, 1);
    chk("to_stray_state", busy, 0);
    tick;
    chk("to_stray_off", stray_done, 0);
    set_req(0, 32'hC0, 16'h5, 16'h6, 8'd2);
    req_valid = 4'b0001;
    #1;
    chk("col_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    serve(TO, {4{32'hDEADBEEF}});
    chk("col_resp_valid", resp_valid, 4'b0001);
    chk("col_err", resp_error, 0);
    chk("col_texel", resp_texel, {4{32'hDEADBEEF}});
    chk("col_stray", stray_done, 0);
    resp_ready = 4'b0001;
    tick;
    resp_ready = '0;
    set_req(2, 32'hE2, 16'h7, 16'h8, 8'd4);
    req_valid = 4'b0100;
    #1;
    chk("rw_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_grant", grant_id, 0);
    chk("rw_tex", tu_tex_id, 0);
    chk("rw_en", tu_sample_en, 0);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_ready0", req_ready, 0);
    req_valid = 4'b1111;
    tick;
    rst = 1'b0;
    #1;
    chk("rw_first", req_ready, 4'b0001);
    req_valid = '0;
    tu_sample_done = 1'b1;
    tick;
    tu_sample_done = 1'b0;
    chk("rw_stray", stray_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
